// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// DIV/DIVU handling depends on the DIVIDE_EN build macro (see ex_muldiv_unit).
package mips_md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_mul(md_op_t op);
        return (op == MULT) || (op == MULTU);
    endfunction

    function automatic logic md_is_div(md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic md_is_signed(md_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle of the multiply/divide unit: op and operands in, busy/done and HI/LO out.
// Build macro DIVIDE_EN does not change this interface.
interface ex_muldiv_unit_if
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();

    md_op_t             MdOpE;
    logic [WIDTH-1:0]   SrcAE;
    logic [WIDTH-1:0]   SrcBE;
    logic               MdBusyE;
    logic               MdDoneE;
    logic [WIDTH-1:0]   HiE;
    logic [WIDTH-1:0]   LoE;

    modport master (
        output MdOpE, SrcAE, SrcBE,
        input  MdBusyE, MdDoneE, HiE, LoE
    );

    modport slave (
        input  MdOpE, SrcAE, SrcBE,
        output MdBusyE, MdDoneE, HiE, LoE
    );

endinterface

// File: rtl/ex_muldiv_unit_div_step.sv
// Combinational single restoring-division step; only built when DIVIDE_EN is defined.
// The shifted partial remainder is WIDTH+1 bits so the subtraction borrow is the quotient bit.
`ifdef DIVIDE_EN
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    assign part    = {rem_in, dvd_bit};
    assign diff    = part - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];

endmodule
`endif

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO registers.
// Build macro DIVIDE_EN adds the restoring divider; without it DIV/DIVU behave as NONE.
module ex_muldiv_unit
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave md
);

    // state | meaning
    // IDLE  | HI/LO stable; accepts MULT*/DIV*/MTHI/MTLO
    // RUN   | one radix-2 step per cycle for WIDTH cycles
    // FIX   | sign fix-up and HI/LO write

    md_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_mul, acc_step, prod;
    logic [WIDTH-1:0]   opnd, hi, lo, hi_res, lo_res;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic               neg_res, done;
    logic               mul_start, div_start, op_sgn, a_neg, b_neg;

    assign mul_start = md_is_mul(md.MdOpE);
    assign op_sgn    = md_is_signed(md.MdOpE);
    assign a_neg     = op_sgn & md.SrcAE[WIDTH-1];
    assign b_neg     = op_sgn & md.SrcBE[WIDTH-1];
    assign mag_a     = a_neg ? -md.SrcAE : md.SrcAE;
    assign mag_b     = b_neg ? -md.SrcBE : md.SrcBE;

    // Shift-add: the W+1-bit sum keeps the carry that becomes the next product MSB.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign acc_mul = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    assign prod    = neg_res ? -acc : acc;

`ifdef DIVIDE_EN
    logic [WIDTH-1:0] rem, rem_nxt, rem_s, quo;
    logic             op_div, neg_rem, dz, q_bit;

    assign div_start = md_is_div(md.MdOpE);

    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (rem),
        .dvd_bit (acc[WIDTH-1]),
        .divisor (opnd),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // A zero divisor leaves the dividend magnitude in rem, so the normal remainder fix restores SrcAE.
    assign quo      = dz ? {WIDTH{1'b1}} : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_s    = neg_rem ? -rem : rem;
    assign acc_step = op_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], q_bit} : acc_mul;
    assign hi_res   = op_div ? rem_s : prod[2*WIDTH-1:WIDTH];
    assign lo_res   = op_div ? quo   : prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            op_div  <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else if (state == IDLE && div_start) begin
            rem     <= '0;
            op_div  <= 1'b1;
            neg_rem <= a_neg;
            dz      <= (md.SrcBE == '0);
        end else if (state == IDLE && mul_start) begin
            op_div  <= 1'b0;
        end else if (state == RUN && op_div) begin
            rem     <= rem_nxt;
        end
    end
`else
    assign div_start = 1'b0;
    assign acc_step  = acc_mul;
    assign hi_res    = prod[2*WIDTH-1:WIDTH];
    assign lo_res    = prod[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        md.MdBusyE = 1'b1;
        case (state)
            IDLE: begin
                md.MdBusyE = 1'b0;
                if (mul_start || div_start) state_nxt = RUN;
            end
            RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: begin
                state_nxt  = IDLE;
                md.MdBusyE = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_start || div_start) begin
                        cnt     <= '0;
                        acc     <= {{WIDTH{1'b0}}, (div_start ? mag_a : mag_b)};
                        opnd    <= div_start ? mag_b : mag_a;
                        neg_res <= a_neg ^ b_neg;
                    end else if (md.MdOpE == MTHI) begin
                        hi <= md.SrcAE;
                    end else if (md.MdOpE == MTLO) begin
                        lo <= md.SrcAE;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_step;
                end
                FIX: begin
                    hi   <= hi_res;
                    lo   <= lo_res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign md.MdDoneE = done;
    assign md.HiE     = hi;
    assign md.LoE     = lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: fixed vectors, multi-cycle corner sequences, random ops
// against an arithmetic reference model. Expectations follow the DIVIDE_EN build macro.
module tb_ex_muldiv_unit;
    import mips_md_pkg::*;

`ifdef DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int LAT = 33;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] m_hi, m_lo;

    ex_muldiv_unit_if #(.WIDTH(32)) bus ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", nm, act, exp);
        end
    endtask

    function automatic void ref_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi_i, input logic [31:0] lo_i,
                                   output logic [31:0] hi_o, output logic [31:0] lo_o);
        longint      sa, sb, sq, sr;
        logic [63:0] up;
        hi_o = hi_i;
        lo_o = lo_i;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (op)
            MULT: begin
                sq   = sa * sb;
                hi_o = sq[63:32];
                lo_o = sq[31:0];
            end
            MULTU: begin
                up   = {32'd0, a} * {32'd0, b};
                hi_o = up[63:32];
                lo_o = up[31:0];
            end
            DIV, DIVU: begin
                if (DIV_EN) begin
                    if (b == 32'd0) begin
                        hi_o = a;
                        lo_o = 32'hFFFF_FFFF;
                    end else if (op == DIV) begin
                        sq   = sa / sb;
                        sr   = sa % sb;
                        lo_o = sq[31:0];
                        hi_o = sr[31:0];
                    end else begin
                        lo_o = a / b;
                        hi_o = a % b;
                    end
                end
            end
            MTHI: hi_o = a;
            MTLO: lo_o = a;
            default: ;
        endcase
    endfunction

    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int   n;
        logic busy_exp;
        busy_exp = md_is_mul(op) || (DIV_EN && md_is_div(op));
        @(negedge clk);
        bus.MdOpE = op;
        bus.SrcAE = a;
        bus.SrcBE = b;
        @(negedge clk);
        bus.MdOpE = NONE;
        bus.SrcAE = $urandom;
        bus.SrcBE = $urandom;
        n = 0;
        while (bus.MdBusyE && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, n, busy_exp ? LAT : 0);
        chk({nm, "_done"}, {31'd0, bus.MdDoneE}, {31'd0, busy_exp});
        chk({nm, "_hi"}, bus.HiE, ehi);
        chk({nm, "_lo"}, bus.LoE, elo);
        @(negedge clk);
        chk({nm, "_done_clear"}, {31'd0, bus.MdDoneE}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[14];
        logic [31:0] ehi, elo, ra, rb;
        md_op_t      rop;
        int          n;

        total = 0;
        bad   = 0;
        m_hi  = '0;
        m_lo  = '0;

        vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{MULT,  32'd0,         32'h1234_5678, 32'h0,         32'h0};
        vecs[3]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[5]  = '{DIV,   32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[7]  = '{MTLO,  32'h55,        32'd0,         32'h0,         32'h0000_0055};
        vecs[8]  = '{MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'h0};
        vecs[9]  = '{MULTU, 32'd3,         32'd4,         32'h0,         32'h0000_000C};
        vecs[10] = '{DIVU,  32'd7,         32'd100,       32'h0000_0007, 32'h0};
        vecs[11] = '{DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF};
        vecs[12] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[13] = '{DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};

        rst       = 1'b1;
        bus.MdOpE = NONE;
        bus.SrcAE = '0;
        bus.SrcBE = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.MdBusyE}, 32'd0);
        chk("reset_done", {31'd0, bus.MdDoneE}, 32'd0);
        chk("reset_hi", bus.HiE, 32'd0);
        chk("reset_lo", bus.LoE, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            ehi = vecs[i].ehi;
            elo = vecs[i].elo;
            if (vecs[i].op == MTHI) elo = m_lo;
            if (vecs[i].op == MTLO) ehi = m_hi;
            if (!DIV_EN && md_is_div(vecs[i].op)) begin
                ehi = m_hi;
                elo = m_lo;
            end
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, ehi, elo, $sformatf("vec%0d", i));
            m_hi = ehi;
            m_lo = elo;
        end

        // MTHI arriving mid-operation must not disturb HI.
        @(negedge clk);
        bus.MdOpE = MULT;
        bus.SrcAE = 32'hFFFF_FFFD;
        bus.SrcBE = 32'd7;
        @(negedge clk);
        bus.MdOpE = NONE;
        repeat (4) @(negedge clk);
        bus.MdOpE = MTHI;
        bus.SrcAE = 32'hAA;
        @(negedge clk);
        bus.MdOpE = NONE;
        chk("mthi_busy_still", {31'd0, bus.MdBusyE}, 32'd1);
        n = 0;
        while (bus.MdBusyE && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mthi_remaining_busy", n, LAT - 5);
        chk("mthi_ignored_hi", bus.HiE, 32'hFFFF_FFFF);
        chk("mthi_ignored_lo", bus.LoE, 32'hFFFF_FFEB);
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;

        // Reset in the middle of RUN aborts and clears HI/LO at once.
        @(negedge clk);
        bus.MdOpE = MULTU;
        bus.SrcAE = 32'hFFFF_FFFF;
        bus.SrcBE = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.MdOpE = NONE;
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", {31'd0, bus.MdBusyE}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.MdBusyE}, 32'd0);
        chk("midrst_hi", bus.HiE, 32'd0);
        chk("midrst_lo", bus.LoE, 32'd0);
        chk("midrst_done", {31'd0, bus.MdDoneE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("midrst_stays_idle", {31'd0, bus.MdBusyE}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            rop = md_op_t'($urandom_range(1, 6));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            ref_md(rop, ra, rb, m_hi, m_lo, ehi, elo);
            do_op(rop, ra, rb, ehi, elo, $sformatf("rnd%0d_op%0d", i, rop));
            m_hi = ehi;
            m_lo = elo;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
